// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: picks the lit block, times its window, scores hits.
// In: clk, reset (sync, active-low), start, btn[3:0]. Out: mole..mole4,
// score[7:0], lives[1:0], hit_pulse, miss_pulse, game_over.
module mole_game_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int UP_MS     = 1000,
  parameter int MIN_UP_MS = 300,
  parameter int STEP_MS   = 100,
  parameter int GAP_MS    = 400,
  parameter int LIVES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] btn,
  output logic       mole,
  output logic       mole2,
  output logic       mole3,
  output logic       mole4,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [15:0] GAP_END = 16'(GAP_MS - 1);
  localparam logic [15:0] UP_INIT = 16'(UP_MS);
  localparam logic [15:0] UP_MIN  = 16'(MIN_UP_MS);
  localparam logic [15:0] UP_STEP = 16'(STEP_MS);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_UP,
    S_HIT,
    S_MISS,
    S_OVER
  } state_t;

  state_t state, state_n;

  logic          start_c, start_p;
  logic [3:0]    btn_c, btn_p;
  logic [TW-1:0] tick_cnt;
  logic [15:0]   ms_cnt;
  logic [15:0]   up_ms;
  logic [15:0]   up_dec;
  logic [7:0]    lfsr;
  logic [7:0]    score_q;
  logic [1:0]    lives_q;
  // idx is the block shown last; it doubles as prev_idx.
  logic [1:0]    idx;
  logic [1:0]    cand;
  logic [1:0]    pick;
  logic [3:0]    idx_oh;
  logic [3:0]    btn_rise;
  logic [3:0]    mole_q;
  logic          hit_q, miss_q;
  logic          ms_tick, start_rise, lfsr_fb;
  logic          hit_now, wrong_now, timeout;

  assign ms_tick    = (tick_cnt == TICK_MAX);
  assign start_rise = start_c & ~start_p;
  assign btn_rise   = btn_c & ~btn_p;
  assign idx_oh     = 4'b0001 << idx;
  assign hit_now    = |(btn_rise & idx_oh);
  assign wrong_now  = |(btn_rise & ~idx_oh);
  assign timeout    = ms_tick && (ms_cnt == up_ms - 16'd1);
  assign lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand       = lfsr[1:0];
  assign pick       = (cand == idx) ? cand + 2'd1 : cand;

  // Clamp first so the subtraction can never wrap.
  assign up_dec = (up_ms >= UP_MIN + UP_STEP) ?
                  up_ms - UP_STEP : UP_MIN;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (start_rise) state_n = S_GAP;
      S_GAP:  if (ms_tick && ms_cnt == GAP_END)
                state_n = S_UP;
      S_UP: begin
        if (hit_now)        state_n = S_HIT;
        else if (wrong_now) state_n = S_MISS;
        else if (timeout)   state_n = S_MISS;
      end
      S_HIT:  state_n = S_GAP;
      S_MISS: state_n = (lives_q == 2'd0) ? S_OVER : S_GAP;
      S_OVER: if (start_rise) state_n = S_GAP;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      start_c  <= 1'b0;
      start_p  <= 1'b0;
      btn_c    <= 4'b0;
      btn_p    <= 4'b0;
      tick_cnt <= '0;
      ms_cnt   <= 16'd0;
      up_ms    <= UP_INIT;
      lfsr     <= 8'hA5;
      score_q  <= 8'd0;
      lives_q  <= LIVES_INIT;
      idx      <= 2'd0;
      mole_q   <= 4'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      start_c  <= start;
      start_p  <= start_c;
      btn_c    <= btn;
      btn_p    <= btn_c;
      lfsr     <= {lfsr[6:0], lfsr_fb};
      tick_cnt <= ms_tick ? '0 : tick_cnt + TICK_ONE;
      state    <= state_n;

      if (state_n != state)
        ms_cnt <= 16'd0;
      else if (ms_tick)
        ms_cnt <= ms_cnt + 16'd1;

      // Registered from the current state: lights one
      // cycle after UP entry, drops one cycle after exit.
      mole_q <= (state == S_UP) ? idx_oh : 4'b0;
      hit_q  <= 1'b0;
      miss_q <= 1'b0;

      if (state == S_GAP && state_n == S_UP)
        idx <= pick;

      if (state == S_UP && state_n == S_HIT) begin
        hit_q <= 1'b1;
        if (score_q != 8'hFF)
          score_q <= score_q + 8'd1;
      end

      if (state == S_UP && state_n == S_MISS) begin
        miss_q <= 1'b1;
        if (lives_q != 2'd0)
          lives_q <= lives_q - 2'd1;
      end

      if (state == S_HIT && score_q[1:0] == 2'b00)
        up_ms <= up_dec;

      if (state == S_OVER && state_n == S_GAP) begin
        score_q <= 8'd0;
        lives_q <= LIVES_INIT;
        up_ms   <= UP_INIT;
      end
    end
  end

  assign mole       = mole_q[0];
  assign mole2      = mole_q[1];
  assign mole3      = mole_q[2];
  assign mole4      = mole_q[3];
  assign score      = score_q;
  assign lives      = lives_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign game_over  = (state == S_OVER);

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Bench for mole_game_ctrl: random press timing and wrong-button choice,
// checked against a score/lives/window model of the game rules.
module tb_mole_game_ctrl;

  localparam int TD    = 4;
  localparam int UPMS  = 10;
  localparam int MINMS = 4;
  localparam int STEP  = 3;
  localparam int GAPMS = 5;
  localparam int NL    = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] btn = 4'b0;
  logic       mole, mole2, mole3, mole4;
  logic [7:0] score;
  logic [1:0] lives;
  logic       hit_pulse, miss_pulse, game_over;
  logic [3:0] moles;

  int checks = 0;
  int failures = 0;
  int m_score, m_lives, m_up;
  int last_idx;

  assign moles = {mole4, mole3, mole2, mole};

  always #5 clk = ~clk;

  mole_game_ctrl #(
    .TICK_DIV(TD), .UP_MS(UPMS), .MIN_UP_MS(MINMS),
    .STEP_MS(STEP), .GAP_MS(GAPMS), .LIVES(NL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn(btn),
    .mole(mole), .mole2(mole2), .mole3(mole3), .mole4(mole4),
    .score(score), .lives(lives), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .game_over(game_over)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Game-rule model
  task automatic model_new();
    m_score = 0;
    m_lives = NL;
    m_up = UPMS;
  endtask

  task automatic model_hit();
    if (m_score < 255) m_score = m_score + 1;
    if (m_score % 4 == 0)
      m_up = (m_up - STEP < MINMS) ? MINMS : m_up - STEP;
  endtask

  task automatic model_miss();
    if (m_lives > 0) m_lives = m_lives - 1;
  endtask

  task automatic do_reset();
    btn = 4'b0;
    start = 1'b0;
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    model_new();
    last_idx = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(2);
    start = 1'b0;
  endtask

  task automatic next_mole(output logic [3:0] v,
                           output int n, output bit rep);
    v = 4'b0;
    n = -1;
    rep = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (moles != 4'b0) begin
        v = moles;
        n = i;
        rep = (idx_of(v) == last_idx);
        last_idx = idx_of(v);
        return;
      end
    end
  endtask

  task automatic wait_miss(input logic [3:0] v,
                           output int n, output bit steady);
    n = -1;
    steady = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      step(1);
      if (moles !== v || hit_pulse) steady = 1'b0;
      if (miss_pulse) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic press(input logic [3:0] b, output int nh,
                       output int nm, output logic [3:0] m3);
    btn = b;
    nh = -1;
    nm = -1;
    m3 = 4'hx;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      if (hit_pulse && nh < 0) nh = i;
      if (miss_pulse && nm < 0) nm = i;
      if (i == 3) m3 = moles;
    end
    btn = 4'b0;
  endtask

  function automatic int rand_delay();
    return int'($urandom_range(4 * (m_up - 1) - 4, 1));
  endfunction

  function automatic logic [3:0] wrong_of(input logic [3:0] v);
    int w;
    w = (idx_of(v) + int'($urandom_range(3, 1))) % 4;
    return 4'b0001 << w;
  endfunction

  task automatic test_reset();
    bit bad;
    reset = 1'b0;
    step(3);
    checks++;
    if (moles !== 4'b0 || hit_pulse !== 1'b0 ||
        miss_pulse !== 1'b0 || game_over !== 1'b0) begin
      failures++;
      $display("FAIL reset_outs moles=%b hit=%b miss=%b over=%b exp 0",
               moles, hit_pulse, miss_pulse, game_over);
    end
    checks++;
    if (score !== 8'd0 || lives !== 2'(NL)) begin
      failures++;
      $display("FAIL reset_regs score=%0d lives=%0d exp 0/%0d",
               score, lives, NL);
    end
    reset = 1'b1;
    model_new();
    last_idx = 0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (moles !== 4'b0 || game_over !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL idle_quiet got activity exp none");
    end
  endtask

  task automatic test_timeout();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep, st;
    do_reset();
    pulse_start();
    next_mole(v, n, rep);
    checks++;
    if (n + 2 < 20 || n + 2 > 23) begin
      failures++;
      $display("FAIL gap_len got=%0d exp 20..23", n + 2);
    end
    checks++;
    if (!$onehot(v)) begin
      failures++;
      $display("FAIL first_onehot got=%b exp one bit", v);
    end
    checks++;
    if (rep) begin
      failures++;
      $display("FAIL first_not_block0 got=%b exp not 0001", v);
    end
    wait_miss(v, n, st);
    model_miss();
    checks++;
    if (n < 4 * (m_up - 1) || n > 4 * m_up - 1) begin
      failures++;
      $display("FAIL up_window got=%0d exp %0d..%0d",
               n, 4 * (m_up - 1), 4 * m_up - 1);
    end
    checks++;
    if (!st) begin
      failures++;
      $display("FAIL mole_steady got=0 exp 1");
    end
    step(1);
    checks++;
    if (miss_pulse !== 1'b0 || moles !== 4'b0 ||
        lives !== 2'(m_lives)) begin
      failures++;
      $display("FAIL after_miss pulse=%b moles=%b lives=%0d exp 0/0/%0d",
               miss_pulse, moles, lives, m_lives);
    end
    next_mole(v, n, rep);
    checks++;
    if (n < 0 || !$onehot(v) || rep) begin
      failures++;
      $display("FAIL mole2 got=%b n=%0d rep=%0d exp new onehot",
               v, n, rep);
    end
    step(rand_delay());
    press(wrong_of(v), nh, nm, m3);
    model_miss();
    checks++;
    if (nm != 2 || nh != -1) begin
      failures++;
      $display("FAIL wrong_btn miss_at=%0d hit_at=%0d exp 2/-1",
               nm, nh);
    end
    checks++;
    if (lives !== 2'(m_lives) || m3 !== 4'b0) begin
      failures++;
      $display("FAIL wrong_lives lives=%0d moles=%b exp %0d/0",
               lives, m3, m_lives);
    end
  endtask

  task automatic test_hit();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep;
    do_reset();
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      next_mole(v, n, rep);
      checks++;
      if (n < 0 || !$onehot(v) || rep) begin
        failures++;
        $display("FAIL hit_mole got=%b n=%0d rep=%0d exp new onehot",
                 v, n, rep);
      end
      if (k == 0) step(8);
      else step(rand_delay());
      press(v, nh, nm, m3);
      model_hit();
      checks++;
      if (nh != 2 || nm != -1) begin
        failures++;
        $display("FAIL hit_pulse hit_at=%0d miss_at=%0d exp 2/-1",
                 nh, nm);
      end
      checks++;
      if (m3 !== 4'b0) begin
        failures++;
        $display("FAIL hit_mole_off got=%b exp 0000", m3);
      end
      checks++;
      if (score !== 8'(m_score) || lives !== 2'(m_lives)) begin
        failures++;
        $display("FAIL hit_score score=%0d lives=%0d exp %0d/%0d",
                 score, lives, m_score, m_lives);
      end
    end
  endtask

  task automatic test_simul();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep;
    next_mole(v, n, rep);
    step(rand_delay());
    press(v | wrong_of(v), nh, nm, m3);
    model_hit();
    checks++;
    if (nh != 2 || nm != -1) begin
      failures++;
      $display("FAIL simul_prio hit_at=%0d miss_at=%0d exp 2/-1",
               nh, nm);
    end
    checks++;
    if (score !== 8'(m_score) || lives !== 2'(m_lives)) begin
      failures++;
      $display("FAIL simul_regs score=%0d lives=%0d exp %0d/%0d",
               score, lives, m_score, m_lives);
    end
  endtask

  task automatic test_over();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep, st, bad;
    do_reset();
    pulse_start();
    next_mole(v, n, rep);
    step(rand_delay());
    press(v, nh, nm, m3);
    model_hit();
    for (int k = 0; k < 3; k++) begin
      next_mole(v, n, rep);
      wait_miss(v, n, st);
      model_miss();
      checks++;
      if (n < 0) begin
        failures++;
        $display("FAIL over_timeout%0d got none exp miss", k);
      end
    end
    step(2);
    checks++;
    if (game_over !== 1'b1 || lives !== 2'd0 ||
        score !== 8'(m_score) || moles !== 4'b0) begin
      failures++;
      $display("FAIL over_state over=%b lives=%0d score=%0d moles=%b exp 1/0/%0d/0",
               game_over, lives, score, moles, m_score);
    end
    btn = 4'hF;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (moles !== 4'b0 || hit_pulse || miss_pulse ||
          game_over !== 1'b1 || lives !== 2'd0 ||
          score !== 8'(m_score)) bad = 1'b1;
    end
    btn = 4'b0;
    step(2);
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL over_hold got change exp none");
    end
    pulse_start();
    model_new();
    step(1);
    checks++;
    if (score !== 8'd0 || lives !== 2'(NL) || game_over !== 1'b0) begin
      failures++;
      $display("FAIL restart score=%0d lives=%0d over=%b exp 0/%0d/0",
               score, lives, game_over, NL);
    end
  endtask

  task automatic test_speedup();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep, st;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 4; k++) begin
        next_mole(v, n, rep);
        step(rand_delay());
        press(v, nh, nm, m3);
        model_hit();
        checks++;
        if (nh != 2 || score !== 8'(m_score)) begin
          failures++;
          $display("FAIL speed_hit hit_at=%0d score=%0d exp 2/%0d",
                   nh, score, m_score);
        end
      end
      next_mole(v, n, rep);
      wait_miss(v, n, st);
      model_miss();
      checks++;
      if (n < 4 * (m_up - 1) || n > 4 * m_up - 1) begin
        failures++;
        $display("FAIL speed_window%0d got=%0d exp %0d..%0d",
                 r, n, 4 * (m_up - 1), 4 * m_up - 1);
      end
    end
    step(2);
    checks++;
    if (game_over !== 1'b1 || lives !== 2'd0) begin
      failures++;
      $display("FAIL speed_over over=%b lives=%0d exp 1/0",
               game_over, lives);
    end
  endtask

  task automatic test_many();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep;
    do_reset();
    pulse_start();
    for (int k = 0; k < 260; k++) begin
      next_mole(v, n, rep);
      checks++;
      if (n < 0 || !$onehot(v)) begin
        failures++;
        $display("FAIL many_onehot%0d got=%b exp one bit", k, v);
      end
      checks++;
      if (rep) begin
        failures++;
        $display("FAIL many_repeat%0d got=%b exp new block", k, v);
      end
      step(rand_delay());
      press(v, nh, nm, m3);
      model_hit();
      checks++;
      if (nh != 2 || score !== 8'(m_score)) begin
        failures++;
        $display("FAIL many_score%0d hit_at=%0d score=%0d exp 2/%0d",
                 k, nh, score, m_score);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] v, m3;
    int n, nh, nm;
    bit rep, bad;
    do_reset();
    pulse_start();
    next_mole(v, n, rep);
    step(rand_delay());
    press(v, nh, nm, m3);
    next_mole(v, n, rep);
    step(3);
    reset = 1'b0;
    step(1);
    checks++;
    if (moles !== 4'b0 || score !== 8'd0 || lives !== 2'(NL) ||
        game_over !== 1'b0 || hit_pulse || miss_pulse) begin
      failures++;
      $display("FAIL reset_mid moles=%b score=%0d lives=%0d over=%b exp 0/0/%0d/0",
               moles, score, lives, game_over, NL);
    end
    reset = 1'b1;
    model_new();
    last_idx = 0;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (moles !== 4'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_mid_idle got mole exp none");
    end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_hit();
    test_simul();
    test_over();
    test_speedup();
    test_many();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
